// File: rtl/encoder_seq.sv
// Frame sequencer in front of the 802.11a convolutional encoder: one SIGNAL word at 6 Mb/s, then N rate-tagged DATA words.
// Build option ENCODER_SEQ_FLUSH_EN adds a FLUSH state that discards surplus upstream beats after a frame that ended without tlast.
module encoder_seq #(
    parameter int WIDTH    = 24,
    parameter int NW_WIDTH = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [31:0]      s_cfg_tdata,
    input  logic             s_cfg_tvalid,
    output logic             s_cfg_tready,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic [3:0]       m_axis_tuser,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic             err
);

    // RATE field with R1 in bit 0; every legal code has R4 (bit 3) set
    localparam logic [3:0] RATE_6M = 4'hB;

    generate
        if (WIDTH != 24) begin : g_width_check
            $error("encoder_seq: WIDTH must be 24");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SIGNAL,
        ST_DATA
`ifdef ENCODER_SEQ_FLUSH_EN
        , ST_FLUSH
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          rate_q, rate_d;
    logic [NW_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    tdata_q, tdata_d;
    logic [3:0]          tuser_q, tuser_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                err_q, err_d;
    logic                in_ready;
    logic                in_hs;
    logic                out_accept;
    logic                cfg_hs;
    logic [NW_WIDTH-1:0] cfg_nwords;
`ifdef ENCODER_SEQ_FLUSH_EN
    logic                miss_q, miss_d;
`endif

    // Parity bit 17 makes bits 17:0 carry an even number of ones
    function automatic logic [23:0] signal_word(input logic [3:0] rate, input logic [11:0] length);
        logic [16:0] low;
        low = {length, 1'b0, rate};
        return {6'd0, ^low, low};
    endfunction

    assign cfg_nwords = NW_WIDTH'(s_cfg_tdata[31:16]);
    assign out_accept = tvalid_q && m_axis_tready;
    assign cfg_hs     = s_cfg_tvalid && cfg_ready_q;

    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        cnt_d       = cnt_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        err_d       = 1'b0;
        in_ready    = 1'b0;
        in_hs       = 1'b0;
`ifdef ENCODER_SEQ_FLUSH_EN
        miss_d      = miss_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_hs) begin
                    if (!s_cfg_tdata[3]) begin
                        err_d = 1'b1;
                    end else begin
                        rate_d   = s_cfg_tdata[3:0];
                        cnt_d    = cfg_nwords;
                        tdata_d  = WIDTH'(signal_word(s_cfg_tdata[3:0], s_cfg_tdata[15:4]));
                        tuser_d  = RATE_6M;
                        tlast_d  = (cfg_nwords == '0);
                        tvalid_d = 1'b1;
                        state_d  = ST_SIGNAL;
                    end
                end
            end
            ST_SIGNAL: begin
                if (out_accept) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    state_d  = (cnt_q == '0) ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                // Refill the output register in the same cycle it drains, so beats stream without bubbles
                in_ready = (!tvalid_q || m_axis_tready) && (cnt_q != '0);
                in_hs    = in_ready && s_axis_tvalid;
                if (in_hs) begin
                    tdata_d  = s_axis_tdata;
                    tuser_d  = rate_q;
                    tlast_d  = (cnt_q == NW_WIDTH'(1));
                    tvalid_d = 1'b1;
                    cnt_d    = cnt_q - NW_WIDTH'(1);
                    err_d    = (cnt_q == NW_WIDTH'(1)) != s_axis_tlast;
`ifdef ENCODER_SEQ_FLUSH_EN
                    miss_d   = (cnt_q == NW_WIDTH'(1)) && !s_axis_tlast;
`endif
                end else if (out_accept) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (tlast_q) begin
`ifdef ENCODER_SEQ_FLUSH_EN
                        state_d = miss_q ? ST_FLUSH : ST_IDLE;
                        miss_d  = 1'b0;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef ENCODER_SEQ_FLUSH_EN
            ST_FLUSH: begin
                in_ready = 1'b1;
                in_hs    = s_axis_tvalid;
                if (in_hs && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cfg_ready_d = (state_d == ST_IDLE) && !tvalid_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            rate_q      <= RATE_6M;
            cnt_q       <= '0;
            tdata_q     <= '0;
            tuser_q     <= RATE_6M;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            cfg_ready_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef ENCODER_SEQ_FLUSH_EN
            miss_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            cnt_q       <= cnt_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            cfg_ready_q <= cfg_ready_d;
            err_q       <= err_d;
`ifdef ENCODER_SEQ_FLUSH_EN
            miss_q      <= miss_d;
`endif
        end
    end

    assign s_cfg_tready  = cfg_ready_q;
    assign s_axis_tready = in_ready;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_encoder_seq.sv
// Self-checking bench for encoder_seq: a frame-level model predicts every output beat and the error-pulse count.
// Directed scenarios cover reset, SIGNAL word construction, streaming under backpressure, errors and mid-frame reset.
module tb_encoder_seq;

    localparam logic [3:0] RATE_6M  = 4'hB;
    localparam logic [3:0] RATE_9M  = 4'hF;
    localparam logic [3:0] RATE_12M = 4'hA;
    localparam logic [3:0] RATE_24M = 4'h9;

    typedef struct packed { logic [23:0] d; logic [3:0] u; logic l; } beat_t;
    typedef struct packed { logic l; logic [23:0] d; } word_t;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_cfg_tdata;
    logic        s_cfg_tvalid;
    logic        s_cfg_tready;
    logic [23:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [23:0] m_axis_tdata;
    logic [3:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        err;

    beat_t exp_q[$];
    beat_t cap_q[$];
    int    cyc_q[$];
    word_t src_q[$];
    word_t model_stream[$];

    int tests = 0;
    int fails = 0;
    int err_seen = 0;
    int exp_err = 0;
    int cycle = 0;
    int ready_mode = 0;
    bit tvalid_seen = 0;

    encoder_seq #(.WIDTH(24), .NW_WIDTH(16)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_cfg_tdata   (s_cfg_tdata),
        .s_cfg_tvalid  (s_cfg_tvalid),
        .s_cfg_tready  (s_cfg_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .err           (err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // SIGNAL word from its definition: rate, LENGTH at bit 5, then a bit that evens out the ones count
    function automatic logic [23:0] sig_model(input logic [3:0] r, input logic [11:0] len);
        int v;
        int ones;
        v = int'(r) + int'(len) * 32;
        ones = 0;
        for (int i = 0; i < 17; i++) ones += (v >> i) & 1;
        if (ones % 2 != 0) v += (1 << 17);
        return 24'(v);
    endfunction

    task automatic stream_word(input logic [23:0] d, input logic l);
        src_q.push_back('{l: l, d: d});
        model_stream.push_back('{l: l, d: d});
    endtask

    task automatic model_frame(input logic [3:0] r, input logic [11:0] len, input logic [15:0] nw);
        word_t w;
        bit    last;
        if (!r[3]) begin
            exp_err++;
            return;
        end
        exp_q.push_back('{d: sig_model(r, len), u: RATE_6M, l: (nw == 16'd0)});
        for (int i = 0; i < int'(nw); i++) begin
            last = (i == int'(nw) - 1);
            if (model_stream.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL model_stream: got empty, expected %0d more words", int'(nw) - i);
                return;
            end
            w = model_stream.pop_front();
            exp_q.push_back('{d: w.d, u: r, l: last});
            if (w.l != last) exp_err++;
`ifdef ENCODER_SEQ_FLUSH_EN
            if (last && !w.l) begin
                while (model_stream.size() > 0) begin
                    w = model_stream.pop_front();
                    if (w.l) break;
                end
            end
`endif
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] r, input logic [11:0] len, input logic [15:0] nw, input bit use_model);
        int n;
        bit done;
        n = 0;
        done = 0;
        @(posedge aclk);
        #1;
        s_cfg_tdata  = {nw, len, r};
        s_cfg_tvalid = 1'b1;
        while (!done && n < 200) begin
            @(negedge aclk);
            if (s_cfg_tready) done = 1;
            @(posedge aclk);
            #1;
            n++;
        end
        s_cfg_tvalid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL cfg_handshake: got no s_cfg_tready, expected it within 200 cycles");
        end else if (use_model) begin
            model_frame(r, len, nw);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while ((exp_q.size() != 0 || m_axis_tvalid || busy) && n < 2000);
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: got %0d beats pending, expected 0 within 2000 cycles", exp_q.size());
        end
        repeat (3) @(negedge aclk);
        check_output("err_count", err_seen, exp_err);
    endtask

    // Downstream ready pattern: 0 steady high, 1 toggling, 2 random, 3 held low
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Upstream source: presents the head of src_q and pops it after each handshake
    initial begin
        bit src_hs;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        forever begin
            @(negedge aclk);
            src_hs = aresetn && s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            #1;
            if (src_hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = src_q[0].d;
                s_axis_tlast  = src_q[0].l;
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
    end

    // Output checker: every accepted beat against the model, plus hold-stable under backpressure
    initial begin
        beat_t exp_b;
        beat_t prev;
        bit    prev_stall;
        prev_stall = 0;
        prev = '0;
        forever begin
            @(negedge aclk);
            cycle++;
            if (aresetn) begin
                if (err) err_seen++;
                if (m_axis_tvalid) tvalid_seen = 1;
                if (prev_stall) begin
                    check_output("hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
                    check_output("hold_beat", {3'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {3'd0, prev});
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    cap_q.push_back('{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast});
                    cyc_q.push_back(cycle);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL extra_beat: got data %h, expected no beat", m_axis_tdata);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check_output("beat_data", {8'd0, m_axis_tdata}, {8'd0, exp_b.d});
                        check_output("beat_user", {28'd0, m_axis_tuser}, {28'd0, exp_b.u});
                        check_output("beat_last", {31'd0, m_axis_tlast}, {31'd0, exp_b.l});
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev = '{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast};
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        aresetn      = 1'b0;
        s_cfg_tdata  = '0;
        s_cfg_tvalid = 1'b0;
        ready_mode   = 0;

        repeat (2) @(negedge aclk);
        check_output("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check_output("rst_tdata", {8'd0, m_axis_tdata}, 32'd0);
        check_output("rst_tuser", {28'd0, m_axis_tuser}, {28'd0, RATE_6M});
        check_output("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check_output("rst_cfg_ready", {31'd0, s_cfg_tready}, 32'd0);
        check_output("rst_in_ready", {31'd0, s_axis_tready}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_err", {31'd0, err}, 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check_output("cfg_ready_release", {31'd0, s_cfg_tready}, 32'd0);
        @(negedge aclk);
        check_output("cfg_ready_idle", {31'd0, s_cfg_tready}, 32'd1);

        // SIGNAL-only frames
        cap_q.delete();
        apply_stimulus(4'hD, 12'd100, 16'd0, 1);
        wait_drain();
        check_output("sig_d100", {8'd0, cap_q[0].d}, 32'h000c8d);
        check_output("sig_d100_user", {28'd0, cap_q[0].u}, {28'd0, RATE_6M});
        check_output("sig_d100_last", {31'd0, cap_q[0].l}, 32'd1);
        check_output("sig_d100_beats", cap_q.size(), 32'd1);
        check_output("sig_d100_busy", {31'd0, busy}, 32'd0);
        check_output("sig_d100_noerr", err_seen, 32'd0);

        cap_q.delete();
        apply_stimulus(4'hF, 12'd1, 16'd0, 1);
        wait_drain();
        apply_stimulus(4'hB, 12'd1, 16'd0, 1);
        wait_drain();
        check_output("sig_f1", {8'd0, cap_q[0].d}, 32'h02002f);
        check_output("sig_b1", {8'd0, cap_q[1].d}, 32'h00002b);

        // Ten-word frame under toggling, then steady, downstream ready
        for (int pass = 0; pass < 2; pass++) begin
            ready_mode = (pass == 0) ? 1 : 0;
            cap_q.delete();
            cyc_q.delete();
            for (int i = 0; i < 10; i++) stream_word(24'h100000 + 24'(i * 24'h01_0101) + 24'(pass), (i == 9));
            apply_stimulus(RATE_9M, 12'd30, 16'd10, 1);
            wait_drain();
            check_output("f10_beats", cap_q.size(), 32'd11);
            check_output("f10_sig", {8'd0, cap_q[0].d}, 32'h0003cf);
            check_output("f10_user", {28'd0, cap_q[5].u}, {28'd0, RATE_9M});
            check_output("f10_last", {31'd0, cap_q[10].l}, 32'd1);
            check_output("f10_word1", {8'd0, cap_q[1].d}, 32'h100000 + pass);
            if (pass == 1) check_output("f10_back_to_back", cyc_q[10] - cyc_q[1], 32'd9);
        end

        // Invalid rate code
        ready_mode  = 0;
        tvalid_seen = 0;
        apply_stimulus(4'h5, 12'd10, 16'd4, 1);
        wait_drain();
        check_output("bad_rate_err", err_seen, 32'd1);
        check_output("bad_rate_no_valid", {31'd0, tvalid_seen}, 32'd0);
        check_output("bad_rate_cfg_ready", {31'd0, s_cfg_tready}, 32'd1);

        // Early tlast and missing tlast in a three-word frame, random backpressure
        ready_mode = 2;
        cap_q.delete();
        stream_word(24'hA00001, 1'b0);
        stream_word(24'hA00002, 1'b1);
        stream_word(24'hA00003, 1'b0);
        stream_word(24'hA00004, 1'b0);
        stream_word(24'hA00005, 1'b1);
        apply_stimulus(RATE_12M, 12'd12, 16'd3, 1);
        wait_drain();
        check_output("short_err", err_seen, 32'd3);
        check_output("short_w3", {8'd0, cap_q[3].d}, 32'hA00003);
        check_output("short_w3_last", {31'd0, cap_q[3].l}, 32'd1);
`ifdef ENCODER_SEQ_FLUSH_EN
        stream_word(24'hA00006, 1'b0);
        stream_word(24'hA00007, 1'b1);
`endif
        apply_stimulus(RATE_24M, 12'd8, 16'd2, 1);
        wait_drain();

        // Reset in the middle of DATA with a beat held in the output register
        ready_mode = 0;
        cap_q.delete();
        src_q.push_back('{l: 1'b0, d: 24'hC00001});
        src_q.push_back('{l: 1'b0, d: 24'hC00002});
        apply_stimulus(RATE_24M, 12'd20, 16'd8, 0);
        exp_q.push_back('{d: sig_model(RATE_24M, 12'd20), u: RATE_6M, l: 1'b0});
        exp_q.push_back('{d: 24'hC00001, u: RATE_24M, l: 1'b0});
        exp_q.push_back('{d: 24'hC00002, u: RATE_24M, l: 1'b0});
        exp_q.push_back('{d: 24'hC00003, u: RATE_24M, l: 1'b0});
        repeat (10) @(negedge aclk);
        check_output("mid_beats", cap_q.size(), 32'd3);
        ready_mode = 3;
        repeat (2) @(negedge aclk);
        src_q.push_back('{l: 1'b0, d: 24'hC00003});
        repeat (4) @(negedge aclk);
        check_output("mid_held_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check_output("mid_busy", {31'd0, busy}, 32'd1);
        check_output("mid_in_ready", {31'd0, s_axis_tready}, 32'd0);
        #2;
        aresetn = 1'b0;
        #1;
        check_output("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_output("mid_rst_cfg_ready", {31'd0, s_cfg_tready}, 32'd0);
        repeat (2) @(negedge aclk);
        exp_q.delete();
        src_q.delete();
        model_stream.delete();
        ready_mode = 0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cap_q.delete();
        stream_word(24'hD00001, 1'b0);
        stream_word(24'hD00002, 1'b1);
        apply_stimulus(RATE_6M, 12'd5, 16'd2, 1);
        wait_drain();
        check_output("post_rst_beats", cap_q.size(), 32'd3);
        check_output("post_rst_last", {8'd0, cap_q[2].d}, 32'hD00002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
